video_histogram: RTL and testbench
==================================

VIDEO_HISTOGRAM -- requirements
Module: video_histogram

Interface
REQ-001 The parameter PIX_W SHALL default to 8 and set the pixel (luma) width.
REQ-002 The parameter BIN_BITS SHALL default to 8 and set the bin count NBINS=2^BIN_BITS, BIN_BITS<=PIX_W, with bin index = pix_i[PIX_W-1 -: BIN_BITS].
REQ-003 The parameter CNT_W SHALL default to 32 and set the bin counter width.
REQ-004 The parameter POL_VS SHALL default to 1; 1 means vs_i is active-high, 0 means vs_i is inverted internally.
REQ-005 The ports SHALL be:
clk  in  1  sole clock;
rst  in  1  asynchronous active-high reset;
pix_i  in  PIX_W  pixel value;
dv_i  in  1  pixel valid;
vs_i  in  1  vertical sync;
rd_strobe_i  in  1  read request level from the AXI domain, asynchronous;
rd_ack_o  out  1  one-cycle pulse, bin_o valid;
bin_o  out  CNT_W  bin value;
bin_idx_o  out  BIN_BITS  index of bin_o;
busy_o  out  1  clearing or counting;
frame_done_o  out  1  one-cycle pulse at the end of counting.

Function
REQ-006 rd_strobe_i SHALL pass through a 2-flop synchronizer; a request is a rising edge of the synchronized level, so rd_ack_o for a serviced request follows rd_strobe_i rising by exactly 3 clk.
REQ-007 The FSM states SHALL be CLEAR, IDLE, WAIT_VS, COUNT, READOUT.
REQ-008 CLEAR: write zero to bins 0..NBINS-1, one per cycle, then go to IDLE; busy_o=1.
REQ-009 IDLE: a request goes to WAIT_VS; no ack is given.
REQ-010 WAIT_VS: the rising edge of normalized vs goes to COUNT.
REQ-011 COUNT: each dv_i=1 cycle increments bin[idx]; the next rising vs edge goes to READOUT, pulses frame_done_o, presents bin 0 and pulses rd_ack_o.
REQ-012 The increment SHALL be a 2-stage read-modify-write; back-to-back pixels in the same bin SHALL forward the in-flight value so no count is lost.
REQ-013 Counters SHALL saturate at 2^CNT_W-1.
REQ-014 READOUT: each request presents bin k+1, zeroes bin k and pulses rd_ack_o; the request after bin NBINS-1 zeroes it, gives no ack and goes to IDLE.
REQ-015 Requests in WAIT_VS, COUNT and CLEAR SHALL be ignored with no ack.
REQ-016 A vs edge during READOUT SHALL be ignored.
REQ-017 A dv_i in cycles other than COUNT SHALL NOT modify any bin.
REQ-018 busy_o SHALL be 1 in CLEAR, WAIT_VS and COUNT.

Reset
REQ-019 Reset SHALL clear the FSM to CLEAR and clear the sync flops, rd_ack_o=0, bin_o=0, bin_idx_o=0, frame_done_o=0 and the pipeline.
REQ-020 Bin storage is not reset directly; the CLEAR sweep zeroes it, so after reset release all bins read 0.
REQ-021 Reset mid-COUNT or mid-READOUT SHALL discard the partial histogram.

Configuration
REQ-022 With HIST_CUMULATIVE_EN defined, bin_o SHALL carry the saturating running sum of bins 0..k (CDF).
REQ-023 Without HIST_CUMULATIVE_EN, bin_o SHALL carry bin k alone; the accumulator logic SHALL be absent.

Structure
REQ-024 The package video_pkg SHALL hold the FSM state enum, the synchronizer depth constant (2) and the saturating-add width rule.
REQ-025 The sub-module strobe_sync SHALL contain the 2-flop synchronizer and rising-edge detector.

Verification
REQ-026 Reset release: after NBINS+2 cycles, busy_o=0; a full readout returns all bins = 0.
REQ-027 Frame of 100 pixels with value 0x10, BIN_BITS=8: bin 16 = 100, all other bins = 0; rd_ack_o arrives 3 clk after each rd_strobe_i rise.
REQ-028 Pixels alternate 0x05,0x05,0x06 continuously for 300 cycles: bin 5 = 200 and bin 6 = 100 (forwarding check).
REQ-029 CNT_W=4 with 20 pixels in bin 3: bin 3 = 15 (saturation); with HIST_CUMULATIVE_EN, the bin 3 readout also = 15.
REQ-030 Request during COUNT: no ack; assert rst mid-READOUT: the FSM returns via CLEAR and a fresh frame counts correctly.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_pkg                                                                  |
// | Shared types and constants for the video luma histogram block.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package video_pkg;

    localparam int c_SYNC_STAGES = 2;

    // Saturating adds are computed this many bits wider than the counter;
    // any set guard bit means the true sum overflowed and clamps to all-ones.
    localparam int c_SAT_GUARD_W = 1;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WAIT_VS = 3'd2,
        ST_COUNT   = 3'd3,
        ST_READOUT = 3'd4
    } hist_state_t;

endpackage
`default_nettype wire

// File: rtl/strobe_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | strobe_sync                                                                |
// | Multi-flop synchronizer for the read-request level plus rise detector.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module strobe_sync
    import video_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_strobe,
    output logic o_rise
);

    logic [c_SYNC_STAGES-1:0] r_sync;
    logic                     r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[c_SYNC_STAGES-2:0], i_strobe};
            r_prev <= r_sync[c_SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[c_SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/video_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_histogram                                                            |
// | Per-frame luma histogram with destructive request-driven readout.          |
// | Define HIST_CUMULATIVE_EN to read out the saturating running sum (CDF).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module video_histogram
    import video_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 32,
    parameter int POL_VS   = 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    pix_i,
    input  logic                dv_i,
    input  logic                vs_i,
    input  logic                rd_strobe_i,
    output logic                rd_ack_o,
    output logic [CNT_W-1:0]    bin_o,
    output logic [BIN_BITS-1:0] bin_idx_o,
    output logic                busy_o,
    output logic                frame_done_o
);

    localparam int                NBINS      = 1 << BIN_BITS;
    localparam int                SUM_W      = CNT_W + c_SAT_GUARD_W;
    localparam logic [BIN_BITS-1:0] c_LAST_BIN = {BIN_BITS{1'b1}};
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};

    hist_state_t          r_state;
    hist_state_t          w_state_nxt;
    logic                 w_req;
    logic                 w_vs;
    logic                 r_vs_prev;
    logic                 w_vs_rise;
    logic [BIN_BITS-1:0]  r_clr_idx;
    logic [BIN_BITS-1:0]  w_pix_idx;
    logic                 w_count_en;
    logic                 w_last_bin;
    logic [CNT_W-1:0]     r_mem [NBINS];
    logic                 w_we;
    logic [BIN_BITS-1:0]  w_waddr;
    logic [CNT_W-1:0]     w_wdata;
    logic [BIN_BITS-1:0]  w_rd_addr;
    logic [CNT_W-1:0]     w_rd_raw;
    logic [CNT_W-1:0]     w_rd_val;
    logic                 r_p1_vld;
    logic [BIN_BITS-1:0]  r_p1_idx;
    logic [CNT_W-1:0]     r_p1_cnt;
    logic [SUM_W-1:0]     w_inc_sum;
    logic [CNT_W-1:0]     w_inc;
    logic [CNT_W-1:0]     w_bin_nxt;
    logic                 w_ack;
    logic                 w_done;
    logic                 w_load;
    logic                 w_first;

    strobe_sync u_strobe_sync (
        .clk      (clk),
        .rst      (rst),
        .i_strobe (rd_strobe_i),
        .o_rise   (w_req)
    );

    assign w_vs       = (POL_VS != 0) ? vs_i : ~vs_i;
    assign w_vs_rise  = w_vs & ~r_vs_prev;
    assign w_pix_idx  = pix_i[PIX_W-1 -: BIN_BITS];
    assign w_last_bin = (bin_idx_o == c_LAST_BIN);
    // A pixel on the frame-closing vs edge belongs to blanking, which keeps the
    // pipeline down to one in-flight write when bin 0 is first presented.
    assign w_count_en = (r_state == ST_COUNT) && dv_i && !w_vs_rise;
    assign busy_o     = (r_state == ST_CLEAR) || (r_state == ST_WAIT_VS) ||
                        (r_state == ST_COUNT);

    // Stage-2 saturating increment and forwarding into the stage-1 read.
    assign w_inc_sum = {{c_SAT_GUARD_W{1'b0}}, r_p1_cnt} + 1'b1;
    assign w_inc     = (|w_inc_sum[CNT_W +: c_SAT_GUARD_W]) ? c_CNT_MAX : w_inc_sum[CNT_W-1:0];
    assign w_rd_raw  = r_mem[w_rd_addr];
    assign w_rd_val  = (r_p1_vld && (r_p1_idx == w_rd_addr)) ? w_inc : w_rd_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_CLEAR;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR:   if (r_clr_idx == c_LAST_BIN)  w_state_nxt = ST_IDLE;
            ST_IDLE:    if (w_req)                     w_state_nxt = ST_WAIT_VS;
            ST_WAIT_VS: if (w_vs_rise)                 w_state_nxt = ST_COUNT;
            ST_COUNT:   if (w_vs_rise)                 w_state_nxt = ST_READOUT;
            ST_READOUT: if (w_req && w_last_bin)       w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        w_we      = r_p1_vld;
        w_waddr   = r_p1_idx;
        w_wdata   = w_inc;
        w_rd_addr = bin_idx_o + 1'b1;
        w_ack     = 1'b0;
        w_done    = 1'b0;
        w_load    = 1'b0;
        w_first   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_idx;
                w_wdata = '0;
            end
            ST_COUNT: begin
                w_rd_addr = w_pix_idx;
                if (w_vs_rise) begin
                    w_rd_addr = '0;
                    w_done    = 1'b1;
                    w_ack     = 1'b1;
                    w_load    = 1'b1;
                    w_first   = 1'b1;
                end
            end
            ST_READOUT: begin
                if (w_req) begin
                    w_we    = 1'b1;
                    w_waddr = bin_idx_o;
                    w_wdata = '0;
                    if (!w_last_bin) begin
                        w_ack  = 1'b1;
                        w_load = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef HIST_CUMULATIVE_EN
    logic [CNT_W-1:0] r_acc;
    logic [SUM_W-1:0] w_cum_sum;

    assign w_cum_sum = (w_first ? {SUM_W{1'b0}} : {{c_SAT_GUARD_W{1'b0}}, r_acc}) +
                       {{c_SAT_GUARD_W{1'b0}}, w_rd_val};
    assign w_bin_nxt = (|w_cum_sum[CNT_W +: c_SAT_GUARD_W]) ? c_CNT_MAX : w_cum_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_acc <= '0;
        else if (w_load) r_acc <= w_bin_nxt;
    end
`else
    assign w_bin_nxt = w_rd_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_prev    <= 1'b0;
            r_clr_idx    <= '0;
            r_p1_vld     <= 1'b0;
            r_p1_idx     <= '0;
            r_p1_cnt     <= '0;
            rd_ack_o     <= 1'b0;
            frame_done_o <= 1'b0;
            bin_o        <= '0;
            bin_idx_o    <= '0;
        end else begin
            r_vs_prev    <= w_vs;
            r_clr_idx    <= (r_state == ST_CLEAR) ? r_clr_idx + 1'b1 : '0;
            r_p1_vld     <= w_count_en;
            r_p1_idx     <= w_pix_idx;
            r_p1_cnt     <= w_rd_val;
            rd_ack_o     <= w_ack;
            frame_done_o <= w_done;
            if (w_load) begin
                bin_o     <= w_bin_nxt;
                bin_idx_o <= w_first ? '0 : bin_idx_o + 1'b1;
            end
        end
    end

    // Bin storage has no reset; the CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_video_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_histogram                                                         |
// | Randomized/directed bench: instance A (defaults), instance B (2 bins bits,  |
// | 4-bit counters, inverted vs) against a per-bin counting model.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_video_histogram;

    localparam int NB_A = 256;
    localparam int NB_B = 4;

    logic        clk = 1'b0;
    logic        r_rst;
    logic [7:0]  r_pix;
    logic        r_dv, r_vs, r_stb_a, r_stb_b;
    logic        w_vs_b;
    logic        w_ack_a, w_busy_a, w_done_a;
    logic [31:0] w_bin_a;
    logic [7:0]  w_idx_a;
    logic        w_ack_b, w_busy_b, w_done_b;
    logic [3:0]  w_bin_b;
    logic [1:0]  w_idx_b;

    int n_pass  = 0;
    int n_total = 0;
    longint unsigned hist [2][NB_A];

    always #5 clk = ~clk;
    assign w_vs_b = ~r_vs;

    video_histogram u_a (
        .clk(clk), .rst(r_rst), .pix_i(r_pix), .dv_i(r_dv), .vs_i(r_vs),
        .rd_strobe_i(r_stb_a), .rd_ack_o(w_ack_a), .bin_o(w_bin_a),
        .bin_idx_o(w_idx_a), .busy_o(w_busy_a), .frame_done_o(w_done_a)
    );

    video_histogram #(.PIX_W(2), .BIN_BITS(2), .CNT_W(4), .POL_VS(0)) u_b (
        .clk(clk), .rst(r_rst), .pix_i(r_pix[7:6]), .dv_i(r_dv), .vs_i(w_vs_b),
        .rd_strobe_i(r_stb_b), .rd_ack_o(w_ack_b), .bin_o(w_bin_b),
        .bin_idx_o(w_idx_b), .busy_o(w_busy_b), .frame_done_o(w_done_b)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int nbins(input int sel);
        return (sel != 0) ? NB_B : NB_A;
    endfunction

    function automatic longint unsigned cnt_max(input int sel);
        return (sel != 0) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    // 0 ack, 1 frame_done, 2 busy, 3 index, 4 bin value
    function automatic logic [63:0] obs(input int sel, input int what);
        case (what)
            0: return (sel != 0) ? 64'(w_ack_b)  : 64'(w_ack_a);
            1: return (sel != 0) ? 64'(w_done_b) : 64'(w_done_a);
            2: return (sel != 0) ? 64'(w_busy_b) : 64'(w_busy_a);
            3: return (sel != 0) ? 64'(w_idx_b)  : 64'(w_idx_a);
            default: return (sel != 0) ? 64'(w_bin_b) : 64'(w_bin_a);
        endcase
    endfunction

    function automatic longint unsigned expect_bin(input int sel, input int k);
        longint unsigned s = 0;
`ifdef HIST_CUMULATIVE_EN
        for (int i = 0; i <= k; i++) s += hist[sel][i];
`else
        s = hist[sel][k];
`endif
        return (s > cnt_max(sel)) ? cnt_max(sel) : s;
    endfunction

    task automatic add_pixel(input int sel, input logic [7:0] p);
        int b;
        b = (sel != 0) ? int'(p[7:6]) : int'(p);
        if (hist[sel][b] < cnt_max(sel)) hist[sel][b]++;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NB_A; i++) hist[s][i] = 0;
    endtask

    task automatic request(input int sel, input bit want_ack, input string tag);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        if (sel != 0) r_stb_b = 1'b1; else r_stb_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (!seen && obs(sel, 0) == 1) begin
                seen = 1;
                lat  = c;
            end
        end
        if (sel != 0) r_stb_b = 1'b0; else r_stb_a = 1'b0;
        repeat (4) tick();
        if (want_ack) check($sformatf("%s ack_latency", tag), 64'(lat), 64'd3);
        else          check($sformatf("%s no_ack", tag), 64'(seen), 64'd0);
    endtask

    // mode 0: all 0x10; 1: 5,5,6 repeating; 2: random; 3: 20 in bin 3 then 5 in bin 1
    task automatic run_frame(input int sel, input int mode, input int npix, input bit mid_req);
        request(sel, 0, "arm");
        r_vs = 1'b1; tick();
        r_vs = 1'b0; tick();
        for (int i = 0; i < npix; i++) begin
            case (mode)
                0: begin r_pix = 8'h10; r_dv = 1'b1; end
                1: begin r_pix = (i % 3 == 2) ? 8'h06 : 8'h05; r_dv = 1'b1; end
                2: begin r_pix = 8'($urandom); r_dv = 1'($urandom_range(0, 1)); end
                default: begin
                    r_pix = (i < 20) ? (8'hC0 | 8'($urandom_range(0, 63)))
                                     : (8'h40 | 8'($urandom_range(0, 63)));
                    r_dv  = 1'b1;
                end
            endcase
            tick();
            if (r_dv) add_pixel(sel, r_pix);
            if (mid_req && i == npix / 2) begin
                r_dv = 1'b0;
                request(sel, 0, "count_req");
            end
        end
        r_dv = 1'b0; tick();
        r_vs = 1'b1; tick();
        check("frame_end ack", obs(sel, 0), 64'd1);
        check("frame_done pulse", obs(sel, 1), 64'd1);
        check("first idx", obs(sel, 3), 64'd0);
        check("bin0", obs(sel, 4), expect_bin(sel, 0));
        r_vs = 1'b0; tick();
        check("frame_done one_cycle", obs(sel, 1), 64'd0);
        check("ack one_cycle", obs(sel, 0), 64'd0);
    endtask

    task automatic readout(input int sel, input string tag);
        r_dv  = 1'b1;
        r_pix = 8'($urandom);
        for (int k = 1; k < nbins(sel); k++) begin
            request(sel, 1, tag);
            check($sformatf("%s idx%0d", tag, k), obs(sel, 3), 64'(k));
            check($sformatf("%s bin%0d", tag, k), obs(sel, 4), expect_bin(sel, k));
            if (k == nbins(sel) / 2) begin
                r_vs = 1'b1; tick();
                r_vs = 1'b0; tick();
            end
        end
        request(sel, 0, $sformatf("%s final", tag));
        check($sformatf("%s idle busy", tag), obs(sel, 2), 64'd0);
        r_dv = 1'b0;
        for (int i = 0; i < NB_A; i++) hist[sel][i] = 0;
    endtask

    task automatic do_reset(input string tag);
        r_rst = 1'b1;
        r_pix = '0; r_dv = 1'b0; r_vs = 1'b0; r_stb_a = 1'b0; r_stb_b = 1'b0;
        repeat (3) tick();
        check($sformatf("%s rst ack", tag),  64'(w_ack_a),  64'd0);
        check($sformatf("%s rst done", tag), 64'(w_done_a), 64'd0);
        check($sformatf("%s rst bin", tag),  64'(w_bin_a),  64'd0);
        check($sformatf("%s rst idx", tag),  64'(w_idx_a),  64'd0);
        check($sformatf("%s rst busy", tag), 64'(w_busy_a), 64'd1);
        r_rst = 1'b0;
        repeat (NB_A + 2) tick();
        check($sformatf("%s clear done A", tag), 64'(w_busy_a), 64'd0);
        check($sformatf("%s clear done B", tag), 64'(w_busy_b), 64'd0);
        clear_model();
    endtask

    initial begin
        do_reset("por");

        run_frame(0, 0, 0, 0);
        readout(0, "zero");

        run_frame(0, 0, 100, 0);
        readout(0, "pix10");

        run_frame(0, 1, 300, 0);
        readout(0, "fwd");

        run_frame(0, 2, 600, 1);
        readout(0, "rand");

        run_frame(1, 3, 25, 0);
        readout(1, "sat");

        run_frame(0, 2, 400, 0);
        r_dv = 1'b0;
        for (int k = 1; k <= 10; k++) request(0, 1, "pre_rst");
        do_reset("mid");

        run_frame(0, 2, 300, 0);
        readout(0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
